fault_pulse_sequencer: RTL and testbench
========================================

Name: fault_pulse_sequencer

Overview:
- Parametrised successor to the single-shot glitch generator.
- Produces a programmable train of fault pulses on GLITCH_OUT, with a scaled delay, a programmable width, gap and repeat count, and an optional external trigger edge.
- Sits between the board controls (buttons/switches or a host register block) and the GPIO pin driving the target's supply or clock glitch circuit.
- A cooldown interval follows every train. The train can be aborted at any time.

Parameters:
- CNT_W, 16: width of the DELAY, WIDTH and GAP inputs.
- NUM_W, 4: width of REPEAT and PULSE_CNT.
- DELAY_SCALE, 100: multiplier applied to DELAY, in clock cycles per unit.
- COOLDOWN, 10000000: cycles spent in COOLDOWN after the last pulse; 0 skips COOLDOWN.
- OUT_IDLE, 1: idle level of GLITCH_OUT; the active level is ~OUT_IDLE.
- SYNC_STAGES, 2: number of synchroniser flops on TRIG_IN (minimum 2).

Ports:
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ARM  in  1  start request, sampled only in IDLE.
- ABORT  in  1  cancels any in-progress train.
- TRIG_MODE  in  2  0 = start on arm, 1 = TRIG_IN rising edge, 2 = TRIG_IN falling edge, 3 = treated as 0.
- TRIG_IN  in  1  asynchronous external trigger.
- DELAY  in  CNT_W  delay before the first pulse, in DELAY_SCALE units.
- WIDTH  in  CNT_W  active cycles per pulse; 0 is treated as 1.
- GAP  in  CNT_W  idle cycles between pulses; 0 is treated as 1.
- REPEAT  in  NUM_W  number of pulses; 0 is treated as 1.
- GLITCH_OUT  out  1  fault pulse output, registered.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle strobe at normal completion.
- PULSE_CNT  out  NUM_W  number of pulses started since the last arm.

Behaviour:
- Reset values: GLITCH_OUT=OUT_IDLE, BUSY=0, DONE=0, PULSE_CNT=0, state=IDLE, synchroniser flops=0. Reset takes effect immediately at any point, including mid-pulse.
- States: IDLE, WAIT_TRIG, DELAY, PULSE, GAP, COOLDOWN.
- Arming:
  - IDLE with ARM=1 and ABORT=0 in cycle N latches DELAY, WIDTH, GAP, REPEAT and TRIG_MODE into shadow registers and clears PULSE_CNT.
  - Input changes after cycle N have no effect on the current train.
  - D = DELAY*DELAY_SCALE, computed at full width (CNT_W + clog2(DELAY_SCALE+1) bits) with no truncation.
  - Next state: DELAY (modes 0/3) or WAIT_TRIG (modes 1/2).
- WAIT_TRIG:
  - TRIG_IN passes through SYNC_STAGES flops, then an edge register that updates every cycle.
  - An edge counts only if it is detected in a cycle spent in WAIT_TRIG. An edge present before arming is ignored.
  - Edge detected in cycle E → DELAY is entered at E+1.
- DELAY:
  - Entered at cycle S. The first PULSE cycle, which is also the first cycle GLITCH_OUT is at the active level, is S+D.
  - D=0 means PULSE is entered directly at S, with no DELAY cycle.
- PULSE:
  - GLITCH_OUT is active for exactly max(WIDTH,1) consecutive cycles.
  - PULSE_CNT increments in the first cycle of each pulse.
  - At the end of a pulse: if pulses started < max(REPEAT,1), go to GAP; otherwise go to COOLDOWN.
- GAP: GLITCH_OUT is idle for exactly max(GAP,1) cycles, then PULSE.
- COOLDOWN:
  - GLITCH_OUT is idle for COOLDOWN cycles, then IDLE.
  - DONE=1 in the last COOLDOWN cycle.
  - If COOLDOWN=0, DONE=1 in the first cycle after the last pulse and the state is IDLE in that same cycle.
- BUSY is 1 from cycle N+1 until the cycle the state returns to IDLE. BUSY=0 in the cycle after DONE.
- ABORT:
  - In any non-IDLE state, the state goes to IDLE next cycle and GLITCH_OUT returns to OUT_IDLE next cycle.
  - DONE is not asserted and PULSE_CNT holds its value.
  - ABORT takes priority over ARM in the same cycle.
  - ABORT in IDLE has no effect.
- ARM while BUSY is ignored. ARM held high re-arms on the first IDLE cycle after completion.
- PULSE_CNT saturates at 2^NUM_W-1 and holds its value after completion until the next arm.
- Internal counters must not wrap for any legal input: delay counter at full D width, width/gap counters CNT_W, cooldown counter sized from COOLDOWN.

Test Plan:
- Mode 0, defaults, DELAY=3, WIDTH=5, REPEAT=1, ARM at cycle 10 → GLITCH_OUT first active at cycle 311, active cycles 311–315, idle from 316; DONE after 10,000,000 cooldown cycles; PULSE_CNT=1.
- COOLDOWN=0, DELAY=0, WIDTH=2, GAP=3, REPEAT=3, ARM at cycle 0 → active at 1–2, 6–7, 11–12; DONE=1 at cycle 13 with BUSY=0 at 13; PULSE_CNT=3.
- Mode 1, DELAY=1, DELAY_SCALE=1: TRIG_IN high before ARM and held → no pulse; TRIG_IN low then high, edge detected at cycle E → active at E+2.
- WIDTH=0, GAP=0, REPEAT=0 → one pulse of width 1, with no GAP state entered.
- ABORT in the 2nd cycle of a WIDTH=10 pulse → GLITCH_OUT=OUT_IDLE next cycle, BUSY=0, no DONE, PULSE_CNT=1; ARM+ABORT in the same IDLE cycle → stays IDLE.
- RESET_N low mid-DELAY and mid-PULSE → all outputs at reset values asynchronously; next ARM after release starts a clean train; OUT_IDLE=0 build inverts all pulse polarities.

Source files
------------

// File: rtl/fault_pulse_sequencer.sv
// Programmable fault-pulse train generator: scaled delay, width, gap and repeat
// count, optional synchronised trigger edge, and a cooldown after each train.
module fault_pulse_sequencer #(
   parameter int   CNT_W       = 16,
   parameter int   NUM_W       = 4,
   parameter int   DELAY_SCALE = 100,
   parameter int   COOLDOWN    = 10000000,
   parameter logic OUT_IDLE    = 1'b1,
   parameter int   SYNC_STAGES = 2
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic             ARM,
   input  logic             ABORT,
   input  logic [1:0]       TRIG_MODE,
   input  logic             TRIG_IN,
   input  logic [CNT_W-1:0] DELAY,
   input  logic [CNT_W-1:0] WIDTH,
   input  logic [CNT_W-1:0] GAP,
   input  logic [NUM_W-1:0] REPEAT,
   output logic             GLITCH_OUT,
   output logic             BUSY,
   output logic             DONE,
   output logic [NUM_W-1:0] PULSE_CNT
);

   localparam int SCALE_W = $clog2(DELAY_SCALE + 1);
   localparam int D_W     = CNT_W + SCALE_W;
   localparam int CD_W    = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam int T_W     = (D_W > CD_W) ? D_W : CD_W;
   localparam int SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam logic [T_W-1:0] CD_LOAD = (COOLDOWN > 0) ? T_W'(COOLDOWN - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_TRIG, S_DELAY, S_PULSE, S_GAP, S_COOLDOWN
   } state_t;

   state_t             state_q, state_d;
   logic [T_W-1:0]     cnt_q, cnt_d;
   logic [NUM_W-1:0]   pcnt_q, pcnt_d, pcnt_base;
   logic               done_q, done_d;
   logic               glitch_q, glitch_d;
   logic [SYNC_N-1:0]  sync_q;
   logic               trig_prev_q;

   logic [1:0]         mode_q, mode_sel;
   logic [CNT_W-1:0]   delay_q, width_q, gap_q, delay_sel, width_sel;
   logic [NUM_W-1:0]   rep_q, rep_eff;
   logic [D_W-1:0]     d_sel;
   logic               arm_go, trig_rise, trig_fall, trig_hit;

   function automatic logic [D_W-1:0] scale_delay(input logic [CNT_W-1:0] d);
      return D_W'(d) * D_W'(DELAY_SCALE);
   endfunction

   // Load value for a countdown of max(v,1) cycles.
   function automatic logic [T_W-1:0] len_m1(input logic [CNT_W-1:0] v);
      return (v == '0) ? '0 : (T_W'(v) - T_W'(1));
   endfunction

   assign arm_go    = (state_q == S_IDLE) && ARM && !ABORT;
   assign mode_sel  = arm_go ? TRIG_MODE : mode_q;
   assign delay_sel = arm_go ? DELAY : delay_q;
   assign width_sel = arm_go ? WIDTH : width_q;
   assign d_sel     = scale_delay(delay_sel);
   assign rep_eff   = (rep_q == '0) ? NUM_W'(1) : rep_q;

   assign trig_rise = sync_q[SYNC_N-1] && !trig_prev_q;
   assign trig_fall = !sync_q[SYNC_N-1] && trig_prev_q;
   assign trig_hit  = ((mode_q == 2'd1) && trig_rise) || ((mode_q == 2'd2) && trig_fall);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (arm_go) begin
               if (mode_sel == 2'd1 || mode_sel == 2'd2) state_d = S_WAIT_TRIG;
               else state_d = (d_sel == '0) ? S_PULSE : S_DELAY;
            end
         end
         S_WAIT_TRIG: if (trig_hit) state_d = (d_sel == '0) ? S_PULSE : S_DELAY;
         S_DELAY:     if (cnt_q == '0) state_d = S_PULSE;
         S_PULSE: begin
            if (cnt_q == '0) begin
               if (pcnt_q >= rep_eff) state_d = (COOLDOWN == 0) ? S_IDLE : S_COOLDOWN;
               else state_d = S_GAP;
            end
         end
         S_GAP:       if (cnt_q == '0) state_d = S_PULSE;
         S_COOLDOWN:  if (cnt_q == '0) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
      if (ABORT && state_q != S_IDLE) state_d = S_IDLE;
   end

   // Counter reloads on every state change and counts down to zero otherwise.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         unique case (state_d)
            S_DELAY:    cnt_d = T_W'(d_sel) - T_W'(1);
            S_PULSE:    cnt_d = len_m1(width_sel);
            S_GAP:      cnt_d = len_m1(gap_q);
            S_COOLDOWN: cnt_d = CD_LOAD;
            default:    cnt_d = '0;
         endcase
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - T_W'(1);
      end
   end

   always_comb begin
      pcnt_base = arm_go ? '0 : pcnt_q;
      pcnt_d    = pcnt_base;
      if (state_d == S_PULSE && state_q != S_PULSE)
         pcnt_d = (pcnt_base == '1) ? pcnt_base : pcnt_base + NUM_W'(1);
      done_d   = ((state_d == S_COOLDOWN) && (cnt_d == '0)) ||
                 ((state_q == S_PULSE) && (state_d == S_IDLE) && !ABORT);
      glitch_d = (state_d == S_PULSE) ? ~OUT_IDLE : OUT_IDLE;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pcnt_q      <= '0;
         done_q      <= 1'b0;
         glitch_q    <= OUT_IDLE;
         sync_q      <= '0;
         trig_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pcnt_q      <= pcnt_d;
         done_q      <= done_d;
         glitch_q    <= glitch_d;
         sync_q      <= {sync_q[SYNC_N-2:0], TRIG_IN};
         trig_prev_q <= sync_q[SYNC_N-1];
      end
   end

   // Shadow copies of the train configuration, frozen at arm time.
   always_ff @(posedge CLOCK_50) begin
      if (arm_go) begin
         mode_q  <= TRIG_MODE;
         delay_q <= DELAY;
         width_q <= WIDTH;
         gap_q   <= GAP;
         rep_q   <= REPEAT;
      end
   end

   assign GLITCH_OUT = glitch_q;
   assign BUSY       = (state_q != S_IDLE);
   assign DONE       = done_q;
   assign PULSE_CNT  = pcnt_q;

endmodule

// File: tb/tb_fault_pulse_sequencer.sv
// Directed bench: instance A (scale 100, cooldown 20, idle-high) and instance B
// (scale 1, no cooldown, idle-low) share clock, reset and stimulus.
module tb_fault_pulse_sequencer;

   logic        clk, rst_n, arm, abort_r, trig;
   logic [1:0]  mode;
   logic [15:0] dly, wid, gp;
   logic [3:0]  rep;
   logic        ga, busy_a, done_a, gb, busy_b, done_b;
   logic [3:0]  pc_a, pc_b;
   int          checks, errors;

   fault_pulse_sequencer #(.DELAY_SCALE(100), .COOLDOWN(20), .OUT_IDLE(1'b1)) u_a (
      .CLOCK_50(clk), .RESET_N(rst_n), .ARM(arm), .ABORT(abort_r), .TRIG_MODE(mode),
      .TRIG_IN(trig), .DELAY(dly), .WIDTH(wid), .GAP(gp), .REPEAT(rep),
      .GLITCH_OUT(ga), .BUSY(busy_a), .DONE(done_a), .PULSE_CNT(pc_a));

   fault_pulse_sequencer #(.DELAY_SCALE(1), .COOLDOWN(0), .OUT_IDLE(1'b0)) u_b (
      .CLOCK_50(clk), .RESET_N(rst_n), .ARM(arm), .ABORT(abort_r), .TRIG_MODE(mode),
      .TRIG_IN(trig), .DELAY(dly), .WIDTH(wid), .GAP(gp), .REPEAT(rep),
      .GLITCH_OUT(gb), .BUSY(busy_b), .DONE(done_b), .PULSE_CNT(pc_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic arm_cfg(input logic [1:0] m, input logic [15:0] d, input logic [15:0] w,
                          input logic [15:0] g, input logic [3:0] r);
      mode = m; dly = d; wid = w; gp = g; rep = r; arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy_a || busy_b) && n < 3000) begin
         tick();
         n++;
      end
      checks++;
      if (busy_a || busy_b) begin
         errors++;
         $display("FAIL wait_idle busy_a=%0b busy_b=%0b required 0 0", busy_a, busy_b);
      end
      tick();
   endtask

   task automatic test_reset();
      checks++;
      if (ga !== 1'b1 || gb !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0 ||
          done_a !== 1'b0 || done_b !== 1'b0 || pc_a !== 4'd0 || pc_b !== 4'd0) begin
         errors++;
         $display("FAIL reset_values ga=%b gb=%b busy=%b%b done=%b%b pc=%0d/%0d required 1 0 00 00 0/0",
                  ga, gb, busy_a, busy_b, done_a, done_b, pc_a, pc_b);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_pulse();
      int first, nact, last, done_r;
      logic b1, b326;
      logic [3:0] pc;
      first = -1; nact = 0; last = -1; done_r = -1; b1 = 1'b0; b326 = 1'b1; pc = '0;
      arm_cfg(2'd0, 16'd3, 16'd5, 16'd1, 4'd1);
      dly = 16'd0; wid = 16'd1; rep = 4'd9;
      for (int r = 1; r <= 330; r++) begin
         if (ga === 1'b0) begin
            if (first < 0) first = r;
            nact++;
            last = r;
         end
         if (done_a === 1'b1 && done_r < 0) done_r = r;
         if (r == 1) b1 = busy_a;
         if (r == 326) b326 = busy_a;
         if (r == 325) pc = pc_a;
         tick();
      end
      checks++;
      if (first != 301) begin errors++; $display("FAIL single_first_active got %0d required 301", first); end
      checks++;
      if (nact != 5 || last != 305) begin
         errors++; $display("FAIL single_width count=%0d last=%0d required 5 305", nact, last);
      end
      checks++;
      if (done_r != 325) begin errors++; $display("FAIL single_done_cycle got %0d required 325", done_r); end
      checks++;
      if (b1 !== 1'b1 || b326 !== 1'b0) begin
         errors++; $display("FAIL single_busy at1=%b at326=%b required 1 0", b1, b326);
      end
      checks++;
      if (pc !== 4'd1) begin errors++; $display("FAIL single_pulse_cnt got %0d required 1", pc); end
      wait_idle();
   endtask

   task automatic test_train();
      logic [16:0] pat_a, pat_b, expv;
      int done_r;
      logic busy13;
      logic [3:0] pc13;
      pat_a = '0; pat_b = '0; expv = '0; done_r = -1; busy13 = 1'b1; pc13 = '0;
      expv[1] = 1'b1; expv[2] = 1'b1; expv[6] = 1'b1; expv[7] = 1'b1; expv[11] = 1'b1; expv[12] = 1'b1;
      arm_cfg(2'd0, 16'd0, 16'd2, 16'd3, 4'd3);
      for (int r = 1; r <= 16; r++) begin
         pat_b[r] = gb;
         pat_a[r] = ~ga;
         if (done_b === 1'b1 && done_r < 0) done_r = r;
         if (r == 13) begin busy13 = busy_b; pc13 = pc_b; end
         tick();
      end
      checks++;
      if (pat_b !== expv) begin errors++; $display("FAIL train_pattern_b got %b required %b", pat_b, expv); end
      checks++;
      if (pat_a !== expv) begin errors++; $display("FAIL train_pattern_a_inverted got %b required %b", pat_a, expv); end
      checks++;
      if (done_r != 13 || busy13 !== 1'b0) begin
         errors++; $display("FAIL train_done done_cycle=%0d busy13=%b required 13 0", done_r, busy13);
      end
      checks++;
      if (pc13 !== 4'd3) begin errors++; $display("FAIL train_pulse_cnt got %0d required 3", pc13); end
      wait_idle();
   endtask

   task automatic test_trigger();
      int nact;
      logic [6:0] pat, expv;
      nact = 0; pat = '0; expv = 7'b0010000;
      trig = 1'b1;
      tick(); tick(); tick();
      arm_cfg(2'd1, 16'd1, 16'd1, 16'd1, 4'd1);
      for (int r = 0; r < 8; r++) begin
         if (gb === 1'b1) nact++;
         tick();
      end
      checks++;
      if (nact != 0 || busy_b !== 1'b1) begin
         errors++; $display("FAIL trig_preexisting_level pulses=%0d busy=%b required 0 1", nact, busy_b);
      end
      trig = 1'b0;
      for (int r = 0; r < 5; r++) tick();
      trig = 1'b1;
      for (int k = 0; k < 7; k++) begin
         pat[k] = gb;
         tick();
      end
      checks++;
      if (pat !== expv) begin errors++; $display("FAIL trig_rise_latency got %b required %b", pat, expv); end
      checks++;
      if (pc_b !== 4'd1) begin errors++; $display("FAIL trig_pulse_cnt got %0d required 1", pc_b); end
      wait_idle();
   endtask

   task automatic test_zero_params();
      logic g1, g2, d2;
      arm_cfg(2'd0, 16'd0, 16'd0, 16'd0, 4'd0);
      g1 = gb;
      tick();
      g2 = gb; d2 = done_b;
      checks++;
      if (g1 !== 1'b1 || g2 !== 1'b0 || d2 !== 1'b1 || pc_b !== 4'd1) begin
         errors++;
         $display("FAIL zero_params g1=%b g2=%b done2=%b pc=%0d required 1 0 1 1", g1, g2, d2, pc_b);
      end
      wait_idle();
   endtask

   task automatic test_abort();
      int ndone;
      ndone = 0;
      arm_cfg(2'd0, 16'd0, 16'd10, 16'd1, 4'd2);
      tick();
      abort_r = 1'b1;
      tick();
      abort_r = 1'b0;
      checks++;
      if (ga !== 1'b1 || gb !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0 ||
          pc_a !== 4'd1 || pc_b !== 4'd1) begin
         errors++;
         $display("FAIL abort_mid_pulse ga=%b gb=%b busy=%b%b pc=%0d/%0d required 1 0 00 1/1",
                  ga, gb, busy_a, busy_b, pc_a, pc_b);
      end
      for (int r = 0; r < 30; r++) begin
         if (done_a === 1'b1 || done_b === 1'b1) ndone++;
         tick();
      end
      checks++;
      if (ndone != 0) begin errors++; $display("FAIL abort_no_done strobes=%0d required 0", ndone); end
      arm = 1'b1; abort_r = 1'b1;
      tick();
      arm = 1'b0; abort_r = 1'b0;
      checks++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
         errors++; $display("FAIL abort_over_arm busy=%b%b required 00", busy_a, busy_b);
      end
      wait_idle();
   endtask

   task automatic test_back_to_back();
      logic g1, g2, g3;
      mode = 2'd0; dly = 16'd0; wid = 16'd1; gp = 16'd1; rep = 4'd1; arm = 1'b1;
      tick();
      g1 = gb; tick();
      g2 = gb; tick();
      g3 = gb;
      arm = 1'b0;
      checks++;
      if (g1 !== 1'b1 || g2 !== 1'b0 || g3 !== 1'b1 || pc_b !== 4'd1) begin
         errors++; $display("FAIL back_to_back g=%b%b%b pc=%0d required 101 1", g1, g2, g3, pc_b);
      end
      wait_idle();
   endtask

   task automatic test_async_reset();
      logic g1, g2, g3;
      arm_cfg(2'd0, 16'd3, 16'd10, 16'd1, 4'd1);
      for (int r = 1; r < 6; r++) tick();
      checks++;
      if (busy_a !== 1'b1 || gb !== 1'b1) begin
         errors++; $display("FAIL reset_precondition busy_a=%b gb=%b required 1 1", busy_a, gb);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (ga !== 1'b1 || gb !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0 || pc_b !== 4'd0 ||
          done_a !== 1'b0 || done_b !== 1'b0) begin
         errors++;
         $display("FAIL async_reset ga=%b gb=%b busy=%b%b pc_b=%0d required 1 0 00 0", ga, gb,
                  busy_a, busy_b, pc_b);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      tick();
      arm_cfg(2'd0, 16'd0, 16'd2, 16'd1, 4'd1);
      g1 = gb; tick();
      g2 = gb; tick();
      g3 = gb;
      checks++;
      if (g1 !== 1'b1 || g2 !== 1'b1 || g3 !== 1'b0 || ga !== 1'b1 || pc_b !== 4'd1) begin
         errors++; $display("FAIL post_reset_train g=%b%b%b ga=%b pc=%0d required 110 1 1", g1, g2, g3, ga, pc_b);
      end
      wait_idle();
   endtask

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0; arm = 1'b0; abort_r = 1'b0; trig = 1'b0; mode = 2'd0;
      dly = '0; wid = '0; gp = '0; rep = '0;
      #12;
      test_reset();
      test_single_pulse();
      test_train();
      test_trigger();
      test_zero_params();
      test_abort();
      test_back_to_back();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
